// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester round-robin UART 8N1/8N2 frame transmitter
module uart_tx_scheduler #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic [DATA_BITS-1:0] req_data0,
  input  logic [DATA_BITS-1:0] req_data1,
  output logic [1:0]           req_ready,
  input  logic                 baud_pulse,
  output logic                 baud_enable,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 prio_q, prio_d;
  logic                 grant_q, grant_d;
  logic                 handshake;
  logic                 sel;

  // Ready is held low while reset is asserted so no requester sees an ack.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == S_IDLE && rst) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = prio_q ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign sel       = req_ready[1];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    prio_d     = prio_q;
    grant_d    = grant_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          shift_d = sel ? req_data1 : req_data0;
          grant_d = sel;
          prio_d  = ~sel;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_pulse) begin
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_pulse) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        if (baud_pulse) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      prio_q     <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      prio_q     <= prio_d;
      grant_q    <= grant_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign baud_enable = (state_q != S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed checks for uart_tx_scheduler (8N1 and 7N2 instances)
module tb_uart_tx_scheduler;

  localparam int PER_A = 16;
  localparam int PER_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [1:0] req_valid_a = 2'b00;
  logic [7:0] req_data0_a = 8'h00;
  logic [7:0] req_data1_a = 8'h00;
  logic [1:0] req_ready_a;
  logic       baud_pulse_a, baud_en_a, tx_a, busy_a, grant_a;
  logic       stray_a = 1'b0;
  logic [4:0] cnt_a = 5'd0;

  logic [1:0] req_valid_b = 2'b00;
  logic [6:0] req_data0_b = 7'h00;
  logic [6:0] req_data1_b = 7'h00;
  logic [1:0] req_ready_b;
  logic       baud_pulse_b, baud_en_b, tx_b, busy_b, grant_b;
  logic       stray_b = 1'b0;
  logic [4:0] cnt_b = 5'd0;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // Baud generator models: counter held at 0 while disabled, strobe on last count.
  always @(posedge clk) cnt_a <= !baud_en_a ? 5'd0 : (cnt_a == 5'(PER_A - 1)) ? 5'd0 : cnt_a + 5'd1;
  always @(posedge clk) cnt_b <= !baud_en_b ? 5'd0 : (cnt_b == 5'(PER_B - 1)) ? 5'd0 : cnt_b + 5'd1;
  assign baud_pulse_a = (baud_en_a && cnt_a == 5'(PER_A - 1)) || stray_a;
  assign baud_pulse_b = (baud_en_b && cnt_b == 5'(PER_B - 1)) || stray_b;

  uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_data0(req_data0_a),
    .req_data1(req_data1_a), .req_ready(req_ready_a), .baud_pulse(baud_pulse_a),
    .baud_enable(baud_en_a), .tx(tx_a), .busy(busy_a), .grant_id(grant_a)
  );

  uart_tx_scheduler #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_data0(req_data0_b),
    .req_data1(req_data1_b), .req_ready(req_ready_b), .baud_pulse(baud_pulse_b),
    .baud_enable(baud_en_b), .tx(tx_b), .busy(busy_b), .grant_id(grant_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a ready, checks which one, then checks the START cycle after the edge.
  task automatic handshake(input bit b, input logic [1:0] exp_ready, input string tag);
    int n;
    n = 0;
    #1;
    while ((b ? req_ready_b : req_ready_a) == 2'b00 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " ready"}, 32'(b ? req_ready_b : req_ready_a), 32'(exp_ready));
    @(negedge clk);
    stray_a = 1'b0;
    stray_b = 1'b0;
    #1;
    check({tag, " start tx/en/busy/ready"},
          b ? {28'd0, tx_b, baud_en_b, busy_b, |req_ready_b}
            : {28'd0, tx_a, baud_en_a, busy_a, |req_ready_a}, 32'b0110);
  endtask

  // Called on the first cycle after the handshake; returns at the first IDLE cycle.
  task automatic run_frame(input bit b, input logic [7:0] data, input int nd, input int ns,
                           input int per, input logic gid, input string tag);
    logic log_tx [0:255];
    int   busy_cnt;
    int   total;
    logic e;
    busy_cnt = 0;
    total    = (1 + nd + ns) * per;
    for (int c = 0; c < total; c++) begin
      log_tx[c] = b ? tx_b : tx_a;
      busy_cnt += int'(b ? busy_b : busy_a);
      @(negedge clk);
    end
    #1;
    check({tag, " busy len"}, 32'(busy_cnt), 32'(total));
    check({tag, " grant"}, 32'(b ? grant_b : grant_a), 32'(gid));
    check({tag, " end busy/en/tx"},
          b ? {29'd0, busy_b, baud_en_b, tx_b} : {29'd0, busy_a, baud_en_a, tx_a}, 32'b001);
    for (int j = 0; j < 1 + nd + ns; j++) begin
      e = (j == 0) ? 1'b0 : (j <= nd) ? data[j-1] : 1'b1;
      check($sformatf("%s bit%0d", tag, j),
            {30'd0, log_tx[j*per], log_tx[j*per+per-1]}, {30'd0, e, e});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset tx/en/busy/grant/ready", {26'd0, tx_a, baud_en_a, busy_a, grant_a, req_ready_a},
          32'b100000);
    rst = 1'b1;

    // Single byte from requester 0
    @(negedge clk);
    req_valid_a = 2'b01;
    req_data0_a = 8'hA5;
    req_data1_a = 8'h3C;
    handshake(1'b0, 2'b01, "single");
    req_valid_a = 2'b00;
    run_frame(1'b0, 8'hA5, 8, 1, PER_A, 1'b0, "single");

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Contention with both valid held: grants alternate and frames are back-to-back
    req_valid_a = 2'b11;
    req_data0_a = 8'h00;
    req_data1_a = 8'hFF;
    for (int f = 0; f < 4; f++) begin
      handshake(1'b0, (f % 2) ? 2'b10 : 2'b01, $sformatf("cont%0d", f));
      run_frame(1'b0, (f % 2) ? 8'hFF : 8'h00, 8, 1, PER_A, 1'(f % 2), $sformatf("cont%0d", f));
    end
    req_valid_a = 2'b00;
    @(negedge clk);

    // Reset during data bit 3; pointer must return to requester 0
    req_valid_a = 2'b11;
    req_data0_a = 8'hF7;
    handshake(1'b0, 2'b01, "midrst");
    repeat (4 * PER_A + 5) @(negedge clk);
    check("midrst pre tx/busy", {30'd0, tx_a, busy_a}, 32'b01);
    #3;
    rst = 1'b0;
    #1;
    check("midrst async tx/en/busy/ready", {27'd0, tx_a, baud_en_a, busy_a, req_ready_a}, 32'b10000);
    @(negedge clk);
    rst = 1'b1;
    handshake(1'b0, 2'b01, "postrst");
    req_valid_a = 2'b00;
    run_frame(1'b0, 8'hF7, 8, 1, PER_A, 1'b0, "postrst");

    // 7N2 instance: stray pulse in IDLE, then a pulse on the handshake cycle
    stray_b = 1'b1;
    @(negedge clk);
    stray_b = 1'b0;
    #1;
    check("stray idle tx/busy", {30'd0, tx_b, busy_b}, 32'b10);
    @(negedge clk);
    req_valid_b = 2'b01;
    req_data0_b = 7'h41;
    stray_b     = 1'b1;
    handshake(1'b1, 2'b01, "p7n2");
    req_valid_b = 2'b00;
    run_frame(1'b1, 8'h41, 7, 2, PER_B, 1'b0, "p7n2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
